// File: rtl/alu_rs_pkg.sv
// Shared constants and types for the integer ALU reservation station.
// Operand widths, default geometry and the opcode field encodings.
package alu_rs_pkg;

  localparam int XLEN          = 32;
  localparam int OP_W          = 11;
  localparam int RS_SIZE_DEF   = 8;
  localparam int ROB_WIDTH_DEF = 4;

  // Low seven bits of the packed {funct7[5], funct3, opcode} op field.
  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  // Result of snooping one operand against the broadcast buses.
  typedef struct packed {
    logic            pending;
    logic [XLEN-1:0] value;
  } operand_res_t;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index-set-bit priority encoder with a found flag.
// Used to pick both the free slot and the ready slot.
module rs_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // NOTE: every output gets a default before the loop, so no latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Walk downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: holds decoded ALU instructions,
// snoops the ALU/LSB broadcast buses for operands, dispatches one per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE   = RS_SIZE_DEF,
  parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 clear_in,

  input  logic                 issue_valid,
  input  logic [OP_W-1:0]      issue_op,
  input  logic                 issue_q1_valid,
  input  logic [ROB_WIDTH-1:0] issue_q1,
  input  logic [XLEN-1:0]      issue_v1,
  input  logic                 issue_q2_valid,
  input  logic [ROB_WIDTH-1:0] issue_q2,
  input  logic [XLEN-1:0]      issue_v2,
  input  logic [XLEN-1:0]      issue_pc,
  input  logic [XLEN-1:0]      issue_imm,
  input  logic [ROB_WIDTH-1:0] issue_rob_id,
  output logic                 full,

  input  logic                 cdb_alu_valid,
  input  logic [ROB_WIDTH-1:0] cdb_alu_rob_id,
  input  logic [XLEN-1:0]      cdb_alu_value,
  input  logic                 cdb_lsb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_lsb_rob_id,
  input  logic [XLEN-1:0]      cdb_lsb_value,

  output logic                 alu_yes,
  output logic [OP_W-1:0]      alu_op,
  output logic [XLEN-1:0]      alu_v1,
  output logic [XLEN-1:0]      alu_v2,
  output logic [XLEN-1:0]      alu_pc,
  output logic [XLEN-1:0]      alu_imm,
  output logic [ROB_WIDTH-1:0] alu_rob_id
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic                 q1_valid;
    logic [ROB_WIDTH-1:0] q1;
    logic [XLEN-1:0]      v1;
    logic                 q2_valid;
    logic [ROB_WIDTH-1:0] q2;
    logic [XLEN-1:0]      v2;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic [ROB_WIDTH-1:0] rob_id;
  } entry_t;

  logic [RS_SIZE-1:0] busy_q;
  entry_t             slot_q [RS_SIZE];
  entry_t             slot_d [RS_SIZE];

  logic [RS_SIZE-1:0] ready_vec;
  logic               free_found, sel_found;
  logic [IDX_W-1:0]   free_idx, sel_idx;
  logic               ins_en, disp_en;

  operand_res_t       wake1 [RS_SIZE];
  operand_res_t       wake2 [RS_SIZE];
  operand_res_t       ins1, ins2;

  // The ALU bus is tested first so it wins when both buses carry the same id.
  function automatic operand_res_t snoop(input logic                 pending,
                                         input logic [ROB_WIDTH-1:0] q,
                                         input logic [XLEN-1:0]      v);
    operand_res_t r;
    r.pending = pending;
    r.value   = v;
    if (pending && cdb_alu_valid && (q == cdb_alu_rob_id)) begin
      r.pending = 1'b0;
      r.value   = cdb_alu_value;
    end else if (pending && cdb_lsb_valid && (q == cdb_lsb_rob_id)) begin
      r.pending = 1'b0;
      r.value   = cdb_lsb_value;
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy_q[i] & ~slot_q[i].q1_valid & ~slot_q[i].q2_valid;
    end
  end

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_enc (
    .req   (~busy_q),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_enc (
    .req   (ready_vec),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // Both strobes come from registered state, so the dispatched slot and the
  // inserted slot are always different entries.
  assign full    = &busy_q;
  assign ins_en  = rdy_in & ~clear_in & issue_valid & free_found;
  assign disp_en = rdy_in & ~clear_in & sel_found;

  always_comb begin
    ins1 = snoop(issue_q1_valid, issue_q1, issue_v1);
    ins2 = snoop(issue_q2_valid, issue_q2, issue_v2);
    for (int i = 0; i < RS_SIZE; i++) begin
      wake1[i]         = snoop(slot_q[i].q1_valid, slot_q[i].q1, slot_q[i].v1);
      wake2[i]         = snoop(slot_q[i].q2_valid, slot_q[i].q2, slot_q[i].v2);
      slot_d[i]        = slot_q[i];
      slot_d[i].q1_valid = wake1[i].pending;
      slot_d[i].v1       = wake1[i].value;
      slot_d[i].q2_valid = wake2[i].pending;
      slot_d[i].v2       = wake2[i].value;
    end
    if (ins_en) begin
      slot_d[free_idx].op       = issue_op;
      slot_d[free_idx].q1_valid = ins1.pending;
      slot_d[free_idx].q1       = issue_q1;
      slot_d[free_idx].v1       = ins1.value;
      slot_d[free_idx].q2_valid = ins2.pending;
      slot_d[free_idx].q2       = issue_q2;
      slot_d[free_idx].v2       = ins2.value;
      slot_d[free_idx].pc       = issue_pc;
      slot_d[free_idx].imm      = issue_imm;
      slot_d[free_idx].rob_id   = issue_rob_id;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        busy_q <= '0;
      end else begin
        if (disp_en) busy_q[sel_idx]  <= 1'b0;
        if (ins_en)  busy_q[free_idx] <= 1'b1;
      end
    end
  end

  // NOTE: slot payload is not reset; busy_q alone qualifies it, which keeps the array a plain register file.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      alu_yes    <= 1'b0;
      alu_op     <= '0;
      alu_v1     <= '0;
      alu_v2     <= '0;
      alu_pc     <= '0;
      alu_imm    <= '0;
      alu_rob_id <= '0;
    end else if (disp_en) begin
      alu_yes    <= 1'b1;
      alu_op     <= slot_q[sel_idx].op;
      alu_v1     <= slot_q[sel_idx].v1;
      alu_v2     <= slot_q[sel_idx].v2;
      alu_pc     <= slot_q[sel_idx].pc;
      alu_imm    <= slot_q[sel_idx].imm;
      alu_rob_id <= slot_q[sel_idx].rob_id;
    end else begin
      // Stall, flush or nothing eligible: drop the strobe, hold the payload.
      alu_yes <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs: issue, wakeup, forwarding,
// fill/drain ordering, flush and stall behaviour.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int RW = 4;

  logic            clk_in = 1'b0;
  logic            rst_n_in, rdy_in, clear_in;
  logic            issue_valid, issue_q1_valid, issue_q2_valid;
  logic [OP_W-1:0] issue_op;
  logic [RW-1:0]   issue_q1, issue_q2, issue_rob_id;
  logic [31:0]     issue_v1, issue_v2, issue_pc, issue_imm;
  logic            full;
  logic            cdb_alu_valid, cdb_lsb_valid;
  logic [RW-1:0]   cdb_alu_rob_id, cdb_lsb_rob_id;
  logic [31:0]     cdb_alu_value, cdb_lsb_value;
  logic            alu_yes;
  logic [OP_W-1:0] alu_op;
  logic [31:0]     alu_v1, alu_v2, alu_pc, alu_imm;
  logic [RW-1:0]   alu_rob_id;

  int checks = 0;
  int errors = 0;

  alu_rs #(.RS_SIZE(8), .ROB_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_q1_valid(issue_q1_valid), .issue_q1(issue_q1), .issue_v1(issue_v1),
    .issue_q2_valid(issue_q2_valid), .issue_q2(issue_q2), .issue_v2(issue_v2),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_rob_id(issue_rob_id),
    .full(full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_id(cdb_alu_rob_id), .cdb_alu_value(cdb_alu_value),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_value(cdb_lsb_value),
    .alu_yes(alu_yes), .alu_op(alu_op), .alu_v1(alu_v1), .alu_v2(alu_v2),
    .alu_pc(alu_pc), .alu_imm(alu_imm), .alu_rob_id(alu_rob_id)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issuing into a full station is a protocol violation.
  always @(posedge clk_in) begin
    if (rst_n_in && rdy_in && !clear_in && issue_valid && full) begin
      errors++;
      $display("FAIL protocol: issue_valid while full");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [OP_W-1:0] op,
                       input logic q1v, input logic [RW-1:0] q1, input logic [31:0] v1,
                       input logic q2v, input logic [RW-1:0] q2, input logic [31:0] v2,
                       input logic [RW-1:0] rob);
    issue_valid    = 1'b1;
    issue_op       = op;
    issue_q1_valid = q1v; issue_q1 = q1; issue_v1 = v1;
    issue_q2_valid = q2v; issue_q2 = q2; issue_v2 = v2;
    issue_pc       = 32'h1000 + 32'(rob) * 4;
    issue_imm      = 32'(rob) + 32'h100;
    issue_rob_id   = rob;
  endtask

  task automatic no_issue();
    issue_valid    = 1'b0;
    issue_q1_valid = 1'b0;
    issue_q2_valid = 1'b0;
  endtask

  task automatic bus_alu(input logic v, input logic [RW-1:0] id, input logic [31:0] val);
    cdb_alu_valid = v; cdb_alu_rob_id = id; cdb_alu_value = val;
  endtask

  task automatic bus_lsb(input logic v, input logic [RW-1:0] id, input logic [31:0] val);
    cdb_lsb_valid = v; cdb_lsb_rob_id = id; cdb_lsb_value = val;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    no_issue();
    issue_op = '0; issue_q1 = '0; issue_q2 = '0; issue_v1 = '0; issue_v2 = '0;
    issue_pc = '0; issue_imm = '0; issue_rob_id = '0;
    bus_alu(1'b0, '0, '0);
    bus_lsb(1'b0, '0, '0);

    // Reset: an issue held during reset must not be captured.
    issue(11'h033, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'h22, 4'd9);
    repeat (3) tick();
    check("rst_alu_yes", 32'(alu_yes), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rob_id", 32'(alu_rob_id), 32'd0);
    check("rst_v1", alu_v1, 32'd0);
    rst_n_in = 1'b1;
    no_issue();
    tick();
    tick();
    check("rst_no_dispatch", 32'(alu_yes), 32'd0);

    // Ready-at-issue add: strobe exactly one cycle after the insert edge.
    issue(11'h033, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3);
    tick();
    no_issue();
    check("add_not_yet", 32'(alu_yes), 32'd0);
    tick();
    check("add_yes", 32'(alu_yes), 32'd1);
    check("add_op", 32'(alu_op), 32'h033);
    check("add_v1", alu_v1, 32'd5);
    check("add_v2", alu_v2, 32'd7);
    check("add_rob", 32'(alu_rob_id), 32'd3);
    check("add_pc", alu_pc, 32'h100c);
    check("add_imm", alu_imm, 32'h103);
    tick();
    check("add_pulse", 32'(alu_yes), 32'd0);
    check("add_hold_rob", 32'(alu_rob_id), 32'd3);

    // rs1 pending on rob 2: waits, then wakes from the ALU bus.
    issue(11'h013, 1'b1, 4'd2, 32'hBAD, 1'b0, 4'd0, 32'd9, 4'd4);
    tick();
    no_issue();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wait_q1", 32'(alu_yes), 32'd0);
    end
    bus_alu(1'b1, 4'd2, 32'h10);
    tick();
    bus_alu(1'b0, '0, '0);
    check("wake_not_yet", 32'(alu_yes), 32'd0);
    tick();
    check("wake_yes", 32'(alu_yes), 32'd1);
    check("wake_v1", alu_v1, 32'h10);
    check("wake_v2", alu_v2, 32'd9);
    check("wake_rob", 32'(alu_rob_id), 32'd4);
    tick();

    // Same-cycle forwarding from the load bus at insert time.
    issue(11'h033, 1'b0, 4'd0, 32'd1, 1'b1, 4'd6, 32'h0, 4'd5);
    bus_lsb(1'b1, 4'd6, 32'hDEAD);
    tick();
    no_issue();
    bus_lsb(1'b0, '0, '0);
    tick();
    check("fwd_yes", 32'(alu_yes), 32'd1);
    check("fwd_v2", alu_v2, 32'hDEAD);
    check("fwd_rob", 32'(alu_rob_id), 32'd5);
    tick();

    // Both buses resolve different operands in one edge.
    issue(11'h033, 1'b1, 4'd9, 32'h0, 1'b1, 4'd10, 32'h0, 4'd7);
    tick();
    no_issue();
    bus_alu(1'b1, 4'd9, 32'h99);
    bus_lsb(1'b1, 4'd10, 32'h1010);
    tick();
    bus_alu(1'b0, '0, '0);
    bus_lsb(1'b0, '0, '0);
    tick();
    check("dual_yes", 32'(alu_yes), 32'd1);
    check("dual_v1", alu_v1, 32'h99);
    check("dual_v2", alu_v2, 32'h1010);

    // Same rob id on both buses: the ALU bus value wins.
    issue(11'h033, 1'b1, 4'd7, 32'h0, 1'b0, 4'd0, 32'h3, 4'd8);
    tick();
    no_issue();
    bus_alu(1'b1, 4'd7, 32'hA);
    bus_lsb(1'b1, 4'd7, 32'hB);
    tick();
    bus_alu(1'b0, '0, '0);
    bus_lsb(1'b0, '0, '0);
    tick();
    check("prio_yes", 32'(alu_yes), 32'd1);
    check("prio_v1", alu_v1, 32'hA);
    tick();

    // Fill all eight entries waiting on rob 1, then drain in entry order.
    for (int i = 0; i < 8; i++) begin
      issue(11'h033, 1'b1, 4'd1, 32'h0, 1'b0, 4'd0, 32'(i), 4'(i + 8));
      tick();
    end
    no_issue();
    check("fill_full", 32'(full), 32'd1);
    check("fill_idle", 32'(alu_yes), 32'd0);
    bus_alu(1'b1, 4'd1, 32'h55);
    tick();
    bus_alu(1'b0, '0, '0);
    check("drain_full_still", 32'(full), 32'd1);
    tick();
    check("drain_full_drop", 32'(full), 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      check("drain_yes", 32'(alu_yes), 32'd1);
      check("drain_rob", 32'(alu_rob_id), 32'(k + 8));
      check("drain_v2", alu_v2, 32'(k));
      check("drain_v1", alu_v1, 32'h55);
    end
    tick();
    check("drain_done", 32'(alu_yes), 32'd0);

    // Flush with four pending entries and a concurrent issue.
    for (int i = 0; i < 4; i++) begin
      issue(11'h033, 1'b1, 4'd2, 32'h0, 1'b0, 4'd0, 32'h0, 4'(i));
      tick();
    end
    issue(11'h033, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 4'd12);
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    no_issue();
    check("clr_full", 32'(full), 32'd0);
    check("clr_yes", 32'(alu_yes), 32'd0);
    bus_alu(1'b1, 4'd2, 32'h77);
    tick();
    bus_alu(1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("clr_no_dispatch", 32'(alu_yes), 32'd0);
    end

    // Stall: rdy_in low freezes everything, including a concurrent issue.
    issue(11'h033, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd4, 4'd11);
    tick();
    issue(11'h033, 1'b0, 4'd0, 32'd8, 1'b0, 4'd0, 32'd8, 4'd13);
    rdy_in = 1'b0;
    tick();
    check("stall_yes0", 32'(alu_yes), 32'd0);
    tick();
    check("stall_yes1", 32'(alu_yes), 32'd0);
    no_issue();
    rdy_in = 1'b1;
    tick();
    check("stall_resume", 32'(alu_yes), 32'd1);
    check("stall_rob", 32'(alu_rob_id), 32'd11);
    tick();
    check("stall_dropped", 32'(alu_yes), 32'd0);

    // Insert and dispatch of another entry in the same edge.
    issue(11'h033, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 4'd1);
    tick();
    issue(11'h033, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 32'd2, 4'd2);
    tick();
    no_issue();
    check("sim_first", 32'(alu_rob_id), 32'd1);
    check("sim_first_yes", 32'(alu_yes), 32'd1);
    tick();
    check("sim_second", 32'(alu_rob_id), 32'd2);
    check("sim_second_yes", 32'(alu_yes), 32'd1);
    tick();
    check("sim_idle", 32'(alu_yes), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
